// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_FWD   = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // addi x0, x0, 0 -- what a flushed or bubbled pipeline register holds.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    LU_FWD   = ST_LU_FWD,
    MEM_WAIT = ST_MEM_WAIT
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Reset and clear win over increment; increment stops at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
//
// Request priority each cycle: dmem_busy, then flush (branch_taken or a
// flush remembered during a memory freeze), then load-use (fresh or
// remembered), then imem_busy. Control outputs are combinational; the WB
// forward selects are registered so they line up with the cycle in which the
// stalled instruction really sits in EX (the LU_FWD cycle).
//
// There is no valid/ready handshake here: every input is a level that is
// sampled each cycle, and every output is a level valid in the same cycle.
import pipe_ctrl_pkg::*;

module pipeline_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_bubble,
  input  logic             fwd_rs1_wb_req,
  input  logic             fwd_rs2_wb_req,
  input  logic             branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic             fwd_rs1_wb_sel,
  output logic             fwd_rs2_wb_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout,
  output logic [1:0]       dbg_state
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state;
  logic            pend_flush;
  logic            pend_lu;
  logic            pend_f1;
  logic            pend_f2;
  logic            lu_in;
  logic            flush_req;
  logic            lu_req;
  logic            lu_f1;
  logic            lu_f2;
  logic [TO_W-1:0] to_cnt;

  assign dbg_state = state;

  // Decode which request owns this cycle and the forward selects a load-use would register.
  always_comb begin
    lu_in     = load_use_bubble && (state != LU_FWD);
    flush_req = branch_taken || pend_flush;
    lu_req    = lu_in || (pend_lu && (state != LU_FWD));
    lu_f1     = (pend_lu && pend_f1) || (lu_in && fwd_rs1_wb_req);
    lu_f2     = (pend_lu && pend_f2) || (lu_in && fwd_rs2_wb_req);
  end

  // Pipeline register enables, flushes and bubbles in priority order.
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (dmem_busy) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (flush_req) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu_req) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (imem_busy) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Sequencer state, requests remembered across a freeze, and the forward selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pend_flush     <= 1'b0;
      pend_lu        <= 1'b0;
      pend_f1        <= 1'b0;
      pend_f2        <= 1'b0;
      fwd_rs1_wb_sel <= 1'b0;
      fwd_rs2_wb_sel <= 1'b0;
    end else if (dmem_busy) begin
      state      <= MEM_WAIT;
      pend_flush <= pend_flush || branch_taken;
      pend_lu    <= pend_lu || lu_in;
      pend_f1    <= pend_f1 || (lu_in && fwd_rs1_wb_req);
      pend_f2    <= pend_f2 || (lu_in && fwd_rs2_wb_req);
    end else begin
      // Any non-frozen cycle consumes or discards everything remembered.
      pend_flush <= 1'b0;
      pend_lu    <= 1'b0;
      pend_f1    <= 1'b0;
      pend_f2    <= 1'b0;
      if (flush_req) begin
        state          <= RUN;
        fwd_rs1_wb_sel <= 1'b0;
        fwd_rs2_wb_sel <= 1'b0;
      end else if (lu_req) begin
        state          <= LU_FWD;
        fwd_rs1_wb_sel <= lu_f1;
        fwd_rs2_wb_sel <= lu_f2;
      end else begin
        state          <= RUN;
        fwd_rs1_wb_sel <= 1'b0;
        fwd_rs2_wb_sel <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (!pc_we),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (!dmem_busy && flush_req),
    .count (flush_count)
  );

  sat_counter #(.W(TO_W)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (!dmem_busy),
    .inc   (dmem_busy),
    .count (to_cnt)
  );

  // Sticky timeout: set on the edge that completes the MEM_TIMEOUT-th consecutive busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_timeout <= 1'b0;
    end else if (dmem_busy && (to_cnt == TO_W'(MEM_TIMEOUT - 1))) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule
